gesture_servo_ctrl: RTL and testbench

- Parametrised multi-channel servo controller for the bionic hand.
- Maps gesture codes from the classifier to per-finger target pulse widths, slews each channel toward its target once per PWM frame, and generates all PWM outputs from one shared frame timer.
- Sits between the gesture classifier and the servo header pins.

---
 rtl/gesture_servo_pkg.sv | 35 +++
 rtl/servo_slew_channel.sv | 52 +++++
 rtl/gesture_servo_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_gesture_servo_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/gesture_servo_pkg.sv
// Shared types, gesture codes and finger indices for the bionic-hand servo controller.
package gesture_servo_pkg;

  typedef logic [15:0] width_t;

  localparam logic [7:0] GEST_HOLD     = 8'h00;
  localparam logic [7:0] GEST_THUMB_LO = 8'h01;
  localparam logic [7:0] GEST_THUMB_HI = 8'h0B;
  localparam logic [7:0] GEST_OPEN     = 8'h20;
  localparam logic [7:0] GEST_FIST     = 8'h21;
  localparam logic [7:0] GEST_POINT    = 8'h22;
  localparam logic [7:0] GEST_PEACE    = 8'h23;

  localparam int FINGER_THUMB  = 0;
  localparam int FINGER_INDEX  = 1;
  localparam int FINGER_MIDDLE = 2;
  localparam int FINGER_RING   = 3;
  localparam int FINGER_PINKY  = 4;
  localparam int NUM_FINGERS   = 5;

  function automatic width_t clamp_width(input logic [31:0] w,
                                         input logic [31:0] lo,
                                         input logic [31:0] hi);
    logic [31:0] r;
    if (w < lo) begin
      r = lo;
    end else if (w > hi) begin
      r = hi;
    end else begin
      r = w;
    end
    return width_t'(r);
  endfunction

endpackage

// File: rtl/servo_slew_channel.sv
// One servo channel: current-width register, per-frame slew toward target, PWM compare.
module servo_slew_channel
  import gesture_servo_pkg::*;
#(
  parameter int WIDTH_INIT_US = 1500,
  parameter int STEP_US       = 20
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   slew_en,
  input  width_t tgt,
  input  width_t frame_us,
  output width_t cur,
  output logic   pwm
);

  localparam logic signed [16:0] STEP_S = 17'(STEP_US);

  logic signed [16:0] diff_s;
  width_t             cur_r;
  width_t             cur_next_s;
  logic               pwm_r;

  // Slew step: 17-bit signed difference so a full-range swing cannot wrap.
  always_comb begin
    diff_s = $signed({1'b0, tgt}) - $signed({1'b0, cur_r});
    if (diff_s > STEP_S) begin
      cur_next_s = cur_r + width_t'(STEP_US);
    end else if (diff_s < -STEP_S) begin
      cur_next_s = cur_r - width_t'(STEP_US);
    end else begin
      cur_next_s = tgt;
    end
  end

  // Current width moves only on frame boundaries; PWM compares against the shared frame counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_r <= width_t'(WIDTH_INIT_US);
      pwm_r <= 1'b0;
    end else begin
      if (slew_en) begin
        cur_r <= cur_next_s;
      end
      pwm_r <= (frame_us < cur_r);
    end
  end

  assign cur = cur_r;
  assign pwm = pwm_r;

endmodule

// File: rtl/gesture_servo_ctrl.sv
// Gesture-driven multi-channel servo controller with a shared PWM frame timer.
// Optional manual per-channel target override is enabled by defining SERVO_MANUAL_EN.
module gesture_servo_ctrl
  import gesture_servo_pkg::*;
#(
  parameter int NUM_CH        = 5,
  parameter int CLK_HZ        = 50_000_000,
  parameter int PERIOD_US     = 20000,
  parameter int WIDTH_MIN_US  = 1000,
  parameter int WIDTH_MAX_US  = 2000,
  parameter int WIDTH_INIT_US = 1500,
  parameter int STEP_US       = 20,
  parameter int GESTURE_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [GESTURE_W-1:0]  gesture,
  input  logic                  gesture_valid,
`ifdef SERVO_MANUAL_EN
  input  logic                  man_valid,
  input  logic [$clog2(NUM_CH)-1:0] man_ch,
  input  logic [15:0]           man_width,
`endif
  output logic [NUM_CH-1:0]     pwm_out,
  output logic                  frame_start,
  output logic                  busy,
  output logic                  err_unknown
);

  localparam int               DIV        = CLK_HZ / 1_000_000;
  localparam int               PRE_W      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(DIV - 1);
  localparam width_t           FRAME_LAST = width_t'(PERIOD_US - 1);
  localparam logic [31:0]      MIN_W      = 32'(WIDTH_MIN_US);
  localparam logic [31:0]      MAX_W      = 32'(WIDTH_MAX_US);
  localparam logic [31:0]      INIT_W     = 32'(WIDTH_INIT_US);

  logic [PRE_W-1:0] presc_r;
  logic [PRE_W-1:0] presc_next_s;
  width_t           frame_us_r;
  width_t           frame_us_next_s;
  logic             us_tick_s;
  logic             frame_edge_s;
  logic             frame_start_r;

  logic [31:0]      code_s;
  logic             dec_mapped_s;
  logic             dec_unknown_s;
  width_t           tgt_r      [NUM_CH];
  width_t           tgt_next_s [NUM_CH];
  width_t           cur_s      [NUM_CH];
  logic             any_diff_s;
  logic             busy_r;
  logic             err_unknown_r;

  // Raw (unclamped) width for one channel under a mapped gesture code.
  function automatic logic [31:0] map_width(input logic [31:0] code, input int ch);
    logic [31:0] w;
    if (ch < NUM_FINGERS) begin
      case (code)
        32'(GEST_OPEN):  w = MIN_W;
        32'(GEST_FIST):  w = MAX_W;
        32'(GEST_POINT): w = (ch == FINGER_INDEX) ? MIN_W : MAX_W;
        32'(GEST_PEACE): w = ((ch == FINGER_INDEX) || (ch == FINGER_MIDDLE)) ? MIN_W : MAX_W;
        default: begin
          if (ch == FINGER_THUMB) begin
            w = 32'd1000 + 32'd100 * (code - 32'd1);
          end else begin
            w = INIT_W;
          end
        end
      endcase
    end else begin
      w = INIT_W;
    end
    return w;
  endfunction

  // Microsecond prescaler and frame counter next-state; frame edge is where both return to zero.
  always_comb begin
    us_tick_s       = (presc_r == PRE_LAST);
    frame_us_next_s = frame_us_r;
    if (us_tick_s) begin
      presc_next_s = '0;
      if (frame_us_r == FRAME_LAST) begin
        frame_us_next_s = '0;
      end else begin
        frame_us_next_s = frame_us_r + 16'd1;
      end
    end else begin
      presc_next_s = presc_r + PRE_W'(1'b1);
    end
    frame_edge_s = (presc_next_s == '0) && (frame_us_next_s == '0);
  end

  // Timebase registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_r       <= '0;
      frame_us_r    <= '0;
      frame_start_r <= 1'b0;
    end else begin
      presc_r       <= presc_next_s;
      frame_us_r    <= frame_us_next_s;
      frame_start_r <= frame_edge_s;
    end
  end

  // Gesture decode and per-channel target selection (manual write wins on its channel).
  always_comb begin
    code_s        = 32'(gesture);
    dec_mapped_s  = ((code_s >= 32'(GEST_THUMB_LO)) && (code_s <= 32'(GEST_THUMB_HI))) ||
                    ((code_s >= 32'(GEST_OPEN)) && (code_s <= 32'(GEST_PEACE)));
    dec_unknown_s = gesture_valid && (code_s != 32'(GEST_HOLD)) && !dec_mapped_s;
    for (int i = 0; i < NUM_CH; i++) begin
`ifdef SERVO_MANUAL_EN
      if (man_valid && (int'(man_ch) == i)) begin
        tgt_next_s[i] = clamp_width(32'(man_width), MIN_W, MAX_W);
      end else if (gesture_valid && dec_mapped_s) begin
        tgt_next_s[i] = clamp_width(map_width(code_s, i), MIN_W, MAX_W);
      end else begin
        tgt_next_s[i] = tgt_r[i];
      end
`else
      if (gesture_valid && dec_mapped_s) begin
        tgt_next_s[i] = clamp_width(map_width(code_s, i), MIN_W, MAX_W);
      end else begin
        tgt_next_s[i] = tgt_r[i];
      end
`endif
    end
  end

  // Target registers and the one-cycle unknown-code flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        tgt_r[i] <= width_t'(WIDTH_INIT_US);
      end
      err_unknown_r <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        tgt_r[i] <= tgt_next_s[i];
      end
      err_unknown_r <= dec_unknown_s;
    end
  end

  // Any channel still travelling toward its target.
  always_comb begin
    any_diff_s = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      any_diff_s = any_diff_s | (cur_s[i] != tgt_r[i]);
    end
  end

  // Registered busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= any_diff_s;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    servo_slew_channel #(
      .WIDTH_INIT_US (WIDTH_INIT_US),
      .STEP_US       (STEP_US)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .slew_en  (frame_edge_s),
      .tgt      (tgt_r[g]),
      .frame_us (frame_us_r),
      .cur      (cur_s[g]),
      .pwm      (pwm_out[g])
    );
  end

  assign frame_start = frame_start_r;
  assign busy        = busy_r;
  assign err_unknown = err_unknown_r;

endmodule

// File: tb/tb_gesture_servo_ctrl.sv
// Directed bench: dut_a (2 MHz, 3000 us frame, 1000 us step) and dut_b (1 MHz, 2001 us frame, 20 us step).
module tb_gesture_servo_ctrl;

  localparam int NCH     = 5;
  localparam int A_FRAME = 6000;
  localparam int B_FRAME = 2001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_a = 1'b1;
  logic           gv_a    = 1'b0;
  logic [7:0]     gest_a  = 8'h00;
  logic [NCH-1:0] pwm_a;
  logic           fs_a, busy_a, err_a;

  logic           reset_b = 1'b1;
  logic           gv_b    = 1'b0;
  logic [7:0]     gest_b  = 8'h00;
  logic [NCH-1:0] pwm_b;
  logic           fs_b, busy_b, err_b;

`ifdef SERVO_MANUAL_EN
  logic        man_valid_a = 1'b0;
  logic [2:0]  man_ch_a    = 3'd0;
  logic [15:0] man_width_a = 16'd0;
  logic        man_valid_b = 1'b0;
  logic [2:0]  man_ch_b    = 3'd0;
  logic [15:0] man_width_b = 16'd0;
`endif

  gesture_servo_ctrl #(.NUM_CH(NCH), .CLK_HZ(2_000_000), .PERIOD_US(3000), .STEP_US(1000)) dut_a (
    .clk(clk), .reset(reset_a), .gesture(gest_a), .gesture_valid(gv_a),
`ifdef SERVO_MANUAL_EN
    .man_valid(man_valid_a), .man_ch(man_ch_a), .man_width(man_width_a),
`endif
    .pwm_out(pwm_a), .frame_start(fs_a), .busy(busy_a), .err_unknown(err_a)
  );

  gesture_servo_ctrl #(.NUM_CH(NCH), .CLK_HZ(1_000_000), .PERIOD_US(2001), .STEP_US(20)) dut_b (
    .clk(clk), .reset(reset_b), .gesture(gest_b), .gesture_valid(gv_b),
`ifdef SERVO_MANUAL_EN
    .man_valid(man_valid_b), .man_ch(man_ch_b), .man_width(man_width_b),
`endif
    .pwm_out(pwm_b), .frame_start(fs_b), .busy(busy_b), .err_unknown(err_b)
  );

  int checks_cnt   = 0;
  int failures_cnt = 0;

  task automatic chk_eq(input string tag, input int obs, input int exp);
    checks_cnt++;
    if (obs != exp) begin
      failures_cnt++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int cyc_a;
  int busy1_a;
  int cnt_a [NCH];

  // From a frame_start sample, run to the next frame_start counting high cycles per channel.
  task automatic measure_a();
    cyc_a   = 0;
    busy1_a = 0;
    for (int i = 0; i < NCH; i++) cnt_a[i] = 0;
    for (int n = 1; n <= 2 * A_FRAME; n++) begin
      step();
      cyc_a = n;
      if (n == 1) busy1_a = int'(busy_a);
      if (fs_a) break;
      for (int i = 0; i < NCH; i++) if (pwm_a[i]) cnt_a[i]++;
    end
  endtask

  task automatic check_frame_a(input string tag, input int w0, input int w1, input int w2,
                               input int w3, input int w4);
    int exp_w [NCH];
    exp_w = '{w0, w1, w2, w3, w4};
    chk_eq({tag, "_period"}, cyc_a, A_FRAME);
    for (int i = 0; i < NCH; i++)
      chk_eq($sformatf("%s_ch%0d", tag, i), cnt_a[i], 2 * exp_w[i]);
  endtask

  task automatic wait_fs_a(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!fs_a && n < 2 * A_FRAME);
    chk_eq(tag, int'(fs_a), 1);
  endtask

  task automatic gesture_a(input logic [7:0] code);
    gest_a = code;
    gv_a   = 1'b1;
    step();
    gv_a   = 1'b0;
    gest_a = 8'h00;
  endtask

  initial begin
    fork
      begin : seq_a
        repeat (3) step();
        chk_eq("rst_pwm", int'(pwm_a), 0);
        chk_eq("rst_busy", int'(busy_a), 0);
        chk_eq("rst_err", int'(err_a), 0);
        chk_eq("rst_fs", int'(fs_a), 0);
        reset_a = 1'b0;
        measure_a();
        check_frame_a("first", 1500, 1500, 1500, 1500, 1500);

        gesture_a(8'h0B);
        chk_eq("thumb_busy_lag", int'(busy_a), 0);
        chk_eq("thumb_err", int'(err_a), 0);
        step();
        chk_eq("thumb_busy_rise", int'(busy_a), 1);
        wait_fs_a("thumb_fs");
        chk_eq("thumb_busy_at_fs", int'(busy_a), 1);
        measure_a();
        chk_eq("thumb_busy_clear", busy1_a, 0);
        check_frame_a("thumb", 2000, 1500, 1500, 1500, 1500);

        gesture_a(8'h21);
        chk_eq("fist_err", int'(err_a), 0);
        wait_fs_a("fist_fs");
        measure_a();
        check_frame_a("fist", 2000, 2000, 2000, 2000, 2000);

        gesture_a(8'h7F);
        chk_eq("unk_err_pulse", int'(err_a), 1);
        step();
        chk_eq("unk_err_single", int'(err_a), 0);
        chk_eq("unk_tgt_hold", int'(busy_a), 0);

        gesture_a(8'h00);
        chk_eq("hold_err", int'(err_a), 0);
        step();
        chk_eq("hold_tgt", int'(busy_a), 0);

        gest_a = 8'h20;
        step();
        step();
        gest_a = 8'h00;
        chk_eq("novalid_tgt", int'(busy_a), 0);

        gesture_a(8'h23);
        wait_fs_a("peace_fs");
        measure_a();
        check_frame_a("peace", 2000, 1000, 1000, 2000, 2000);

        repeat (2400) step();
        chk_eq("mid_pwm_before", int'(pwm_a), 25);
        reset_a = 1'b1;
        step();
        chk_eq("mid_pwm_drop", int'(pwm_a), 0);
        chk_eq("mid_busy", int'(busy_a), 0);
        chk_eq("mid_fs", int'(fs_a), 0);
        reset_a = 1'b0;
        measure_a();
        check_frame_a("mid_restart", 1500, 1500, 1500, 1500, 1500);

`ifdef SERVO_MANUAL_EN
        man_valid_a = 1'b1;
        man_ch_a    = 3'd2;
        man_width_a = 16'd2500;
        gesture_a(8'h20);
        man_valid_a = 1'b0;
        wait_fs_a("man_fs");
        measure_a();
        check_frame_a("manual", 1000, 1000, 2000, 1000, 1000);
`endif
      end

      begin : seq_b
        int c0, c4, b1, exp_w, n;
        repeat (3) step();
        reset_b = 1'b0;
        gest_b  = 8'h21;
        gv_b    = 1'b1;
        step();
        gv_b    = 1'b0;
        gest_b  = 8'h00;
        step();
        chk_eq("ramp_busy_rise", int'(busy_b), 1);
        n = 0;
        do begin
          step();
          n++;
        end while (!fs_b && n < 2 * B_FRAME);
        chk_eq("ramp_first_fs", int'(fs_b), 1);
        for (int f = 1; f <= 25; f++) begin
          exp_w = 1500 + 20 * f;
          chk_eq($sformatf("ramp_busy_fs%0d", f), int'(busy_b), 1);
          c0 = 0;
          c4 = 0;
          b1 = 0;
          for (int m = 1; m <= 2 * B_FRAME; m++) begin
            step();
            if (m == 1) b1 = int'(busy_b);
            if (fs_b) break;
            if (pwm_b[0]) c0++;
            if (pwm_b[4]) c4++;
          end
          chk_eq($sformatf("ramp_w0_f%0d", f), c0, exp_w);
          chk_eq($sformatf("ramp_w4_f%0d", f), c4, exp_w);
          chk_eq($sformatf("ramp_busy_after_f%0d", f), b1, (f < 25) ? 1 : 0);
        end
        chk_eq("ramp_done_busy", int'(busy_b), 0);
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
    $finish;
  end

endmodule
